// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int STARVE_CNT_W = 4;
    localparam int REG_ZERO     = 0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_t;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; a new request arriving on the clearing edge wins.
module wb_slot
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              slot_valid,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_data
);
    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              load;

    // Ready depends only on slot state so requesters never see a combinational loop.
    assign in_ready = !valid_reg || clear;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            addr_reg  <= in_addr;
            data_reg  <= in_data;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end
    end

    assign slot_valid = valid_reg;
    assign slot_addr  = addr_reg;
    assign slot_data  = data_reg;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (A) and mul/div (B),
// fixed priority to A with a starvation counter forcing B through.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_a_valid,
    output logic              req_a_ready,
    input  logic [ADDR_W-1:0] req_a_addr,
    input  logic [DATA_W-1:0] req_a_data,
    input  logic              req_b_valid,
    output logic              req_b_ready,
    input  logic [ADDR_W-1:0] req_b_addr,
    input  logic [DATA_W-1:0] req_b_data,
    output logic              ctrl_writeEnable,
    output logic [ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              wr_data_is_zero,
    output logic              zero_drop,
    output logic              busy
);
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

    logic [1:0]              in_valid;
    logic [1:0]              in_ready;
    logic [1:0]              clear;
    logic [1:0]              s_valid;
    logic [ADDR_W-1:0]       in_addr [2];
    logic [DATA_W-1:0]       in_data [2];
    logic [ADDR_W-1:0]       s_addr  [2];
    logic [DATA_W-1:0]       s_data  [2];

    grant_t                  grant;
    logic [STARVE_CNT_W-1:0] starve_cnt_reg;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_data;

    assign in_valid = {req_b_valid, req_a_valid};
    assign in_addr[0] = req_a_addr;
    assign in_addr[1] = req_b_addr;
    assign in_data[0] = req_a_data;
    assign in_data[1] = req_b_data;
    assign req_a_ready = in_ready[0];
    assign req_b_ready = in_ready[1];
    assign clear = {grant == GNT_B, grant == GNT_A};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
                .clock      (clock),
                .reset_n    (reset_n),
                .in_valid   (in_valid[gi]),
                .in_ready   (in_ready[gi]),
                .in_addr    (in_addr[gi]),
                .in_data    (in_data[gi]),
                .clear      (clear[gi]),
                .slot_valid (s_valid[gi]),
                .slot_addr  (s_addr[gi]),
                .slot_data  (s_data[gi])
            );
        end
    endgenerate

    always_comb begin
        grant = GNT_NONE;
        if (s_valid[0] && s_valid[1]) begin
            grant = (starve_cnt_reg == STARVE_LIMIT) ? GNT_B : GNT_A;
        end else if (s_valid[0]) begin
            grant = GNT_A;
        end else if (s_valid[1]) begin
            grant = GNT_B;
        end
    end

    always_comb begin
        sel_addr = s_addr[0];
        sel_data = s_data[0];
        if (grant == GNT_B) begin
            sel_addr = s_addr[1];
            sel_data = s_data[1];
        end
    end

    // Counts cycles B sits valid behind A; saturates at the force-grant threshold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_reg <= '0;
        end else if (!s_valid[1] || grant == GNT_B) begin
            starve_cnt_reg <= '0;
        end else if (starve_cnt_reg != STARVE_LIMIT) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            wr_data_is_zero  <= 1'b0;
            zero_drop        <= 1'b0;
        end else if (grant != GNT_NONE) begin
            ctrl_writeEnable <= (sel_addr != ADDR_W'(REG_ZERO));
            zero_drop        <= (sel_addr == ADDR_W'(REG_ZERO));
            ctrl_writeReg    <= sel_addr;
            data_writeReg    <= sel_data;
            wr_data_is_zero  <= ~|sel_data;
        end else begin
            ctrl_writeEnable <= 1'b0;
            zero_drop        <= 1'b0;
        end
    end

    assign busy = |s_valid;
endmodule
